// File: rtl/e_mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at launch into
// shadow registers and committed to HI/LO when the busy countdown expires.
module e_mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       MDUOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d, sl_q, sl_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0]        prod_sgn_s, prod_uns_s;
  logic signed [WIDTH-1:0]   quo_sgn_s, rem_sgn_s;
  logic [WIDTH-1:0]          quo_uns_s, rem_uns_s;
  logic [WIDTH-1:0]          res_hi_s, res_lo_s;
  logic [CNT_W-1:0]          cyc_s;
  logic                      launch_s;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the product the signed product.
  assign prod_sgn_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_uns_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign quo_sgn_s  = $signed(A) / $signed(B);
  assign rem_sgn_s  = $signed(A) % $signed(B);
  assign quo_uns_s  = A / B;
  assign rem_uns_s  = A % B;

  always_comb begin
    res_hi_s = '0;
    res_lo_s = '0;
    launch_s = 1'b0;
    cyc_s    = MULT_N;
    case (MDUOp)
      OP_MULT: begin
        launch_s = Start;
        {res_hi_s, res_lo_s} = prod_sgn_s;
      end
      OP_MULTU: begin
        launch_s = Start;
        {res_hi_s, res_lo_s} = prod_uns_s;
      end
      OP_MADD: begin
        launch_s = Start;
        {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_sgn_s;
      end
      OP_MADDU: begin
        launch_s = Start;
        {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_uns_s;
      end
      OP_DIV: begin
        launch_s = Start;
        cyc_s    = DIV_N;
        if (B == '0) begin
          res_lo_s = '1;
          res_hi_s = A;
        end else if ((A == MOST_NEG) && (B == '1)) begin
          res_lo_s = MOST_NEG;
          res_hi_s = '0;
        end else begin
          res_lo_s = $unsigned(quo_sgn_s);
          res_hi_s = $unsigned(rem_sgn_s);
        end
      end
      OP_DIVU: begin
        launch_s = Start;
        cyc_s    = DIV_N;
        if (B == '0) begin
          res_lo_s = '1;
          res_hi_s = A;
        end else begin
          res_lo_s = quo_uns_s;
          res_hi_s = rem_uns_s;
        end
      end
      default: begin
        launch_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          state_d = S_RUN;
          cnt_d   = cyc_s;
          sh_d    = res_hi_s;
          sl_d    = res_lo_s;
        end else if (MDUOp == OP_MTHI) begin
          hi_d = A;
        end else if (MDUOp == OP_MTLO) begin
          lo_d = A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = sh_q;
          lo_d    = sl_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu_multicycle.sv
// Directed self-checking bench for e_mdu_multicycle (default 32-bit unit plus a
// 16-bit single-cycle multiply instance).
module tb_e_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [3:0]  op = 4'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [3:0]  op16 = 4'd0;
  logic        start16 = 1'b0;
  logic        busy16;
  logic [15:0] hi16, lo16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e_mdu_multicycle dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .MDUOp(op), .Start(start),
    .Busy(busy), .HI(hi), .LO(lo)
  );

  e_mdu_multicycle #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .MDUOp(op16), .Start(start16),
    .Busy(busy16), .HI(hi16), .LO(lo16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0; op = 4'd0; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A;
  endtask

  // Counts remaining busy cycles, bounded so a stuck Busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks += 6;
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    if (busy16 !== 1'b0)   begin errors++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    if (hi16 !== 16'd0)    begin errors++; $display("FAIL reset_hi16: got %h expected 0", hi16); end
    if (lo16 !== 16'd0)    begin errors++; $display("FAIL reset_lo16: got %h expected 0", lo16); end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int n = 0;
    launch(4'd2, 32'hFFFF_FFFF, 32'd2);
    while (busy && n < 100) begin
      n++;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
        errors++; $display("FAIL multu_hold: got hi=%h lo=%h expected 0/0 in busy cycle %0d", hi, lo, n);
      end
      step();
    end
    checks += 3;
    if (n != 5)                begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
    if (hi !== 32'h0000_0001)  begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    if (lo !== 32'hFFFF_FFFE)  begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
  endtask

  task automatic test_mult_signed();
    int n;
    launch(4'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    checks += 3;
    if (n != 5)                begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
    if (hi !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    if (lo !== 32'hFFFF_FFF1)  begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
  endtask

  task automatic test_div_signed();
    int n;
    launch(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks += 3;
    if (n != 10)               begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
    if (lo !== 32'hFFFF_FFFD)  begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    if (hi !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
  endtask

  task automatic test_div_corners();
    int n;
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks += 2;
    if (lo !== 32'h8000_0000)  begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    if (hi !== 32'h0000_0000)  begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", hi); end
    launch(4'd4, 32'h0000_1234, 32'd0);
    wait_idle(n);
    checks += 3;
    if (n != 10)               begin errors++; $display("FAIL divu_z_cycles: got %0d expected 10", n); end
    if (lo !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL divu_z_lo: got %h expected ffffffff", lo); end
    if (hi !== 32'h0000_1234)  begin errors++; $display("FAIL divu_z_hi: got %h expected 00001234", hi); end
    launch(4'd3, 32'hFFFF_FFFB, 32'd0);
    wait_idle(n);
    checks += 2;
    if (lo !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL div_z_lo: got %h expected ffffffff", lo); end
    if (hi !== 32'hFFFF_FFFB)  begin errors++; $display("FAIL div_z_hi: got %h expected fffffffb", hi); end
    launch(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    checks += 2;
    if (lo !== 32'd14)         begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    if (hi !== 32'd2)          begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_madd();
    int n;
    op = 4'd5; a = 32'd0; step();
    op = 4'd6; a = 32'hFFFF_FFFF; step();
    op = 4'd0;
    checks += 2;
    if (hi !== 32'd0)          begin errors++; $display("FAIL mthi: got %h expected 0", hi); end
    if (lo !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL mtlo: got %h expected ffffffff", lo); end
    launch(4'd7, 32'd1, 32'd1);
    wait_idle(n);
    checks += 3;
    if (n != 5)                begin errors++; $display("FAIL madd_cycles: got %0d expected 5", n); end
    if (hi !== 32'd1)          begin errors++; $display("FAIL madd_hi: got %h expected 00000001", hi); end
    if (lo !== 32'd0)          begin errors++; $display("FAIL madd_lo: got %h expected 0", lo); end
    launch(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_idle(n);
    checks += 2;
    if (hi !== 32'd0)          begin errors++; $display("FAIL madd_neg_hi: got %h expected 0", hi); end
    if (lo !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL madd_neg_lo: got %h expected ffffffff", lo); end
    launch(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks += 2;
    if (hi !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL maddu_hi: got %h expected ffffffff", hi); end
    if (lo !== 32'd0)          begin errors++; $display("FAIL maddu_lo: got %h expected 0", lo); end
  endtask

  task automatic test_ignored();
    int n;
    launch(4'd1, 32'd2, 32'd2);
    step();
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
    step();
    start = 1'b0; op = 4'd6; a = 32'h0000_DEAD;
    step();
    op = 4'd0;
    wait_idle(n);
    checks += 3;
    if (n + 3 != 5)            begin errors++; $display("FAIL ign_cycles: got %0d expected 5", n + 3); end
    if (lo !== 32'd4)          begin errors++; $display("FAIL ign_lo: got %h expected 00000004", lo); end
    if (hi !== 32'd0)          begin errors++; $display("FAIL ign_hi: got %h expected 0", hi); end
    step();
    checks++;
    if (busy !== 1'b0)         begin errors++; $display("FAIL ign_restart: got busy %b expected 0", busy); end
    start = 1'b1; op = 4'd9; a = 32'd7; b = 32'd7;
    step();
    start = 1'b0; op = 4'd0;
    checks += 2;
    if (busy !== 1'b0)         begin errors++; $display("FAIL bad_op_busy: got %b expected 0", busy); end
    if (lo !== 32'd4)          begin errors++; $display("FAIL bad_op_lo: got %h expected 00000004", lo); end
  endtask

  task automatic test_reset_mid();
    launch(4'd3, 32'd100, 32'd7);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 3;
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (hi !== 32'd0)          begin errors++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
    if (lo !== 32'd0)          begin errors++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
    for (int i = 0; i < 15; i++) step();
    checks += 3;
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_late_busy: got %b expected 0", busy); end
    if (hi !== 32'd0)          begin errors++; $display("FAIL rst_late_hi: got %h expected 0", hi); end
    if (lo !== 32'd0)          begin errors++; $display("FAIL rst_late_lo: got %h expected 0", lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(4'd2, 32'd3, 32'd4);
    wait_idle(n);
    launch(4'd4, 32'd50, 32'd8);
    checks += 3;
    if (busy !== 1'b1)         begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    if (lo !== 32'd12)         begin errors++; $display("FAIL b2b_first_lo: got %h expected 0000000c", lo); end
    if (hi !== 32'd0)          begin errors++; $display("FAIL b2b_first_hi: got %h expected 0", hi); end
    wait_idle(n);
    checks += 3;
    if (n != 10)               begin errors++; $display("FAIL b2b_cycles: got %0d expected 10", n); end
    if (lo !== 32'd6)          begin errors++; $display("FAIL b2b_lo: got %h expected 00000006", lo); end
    if (hi !== 32'd2)          begin errors++; $display("FAIL b2b_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_mult16();
    int n = 0;
    start16 = 1'b1; op16 = 4'd1; a16 = 16'h8000; b16 = 16'h8000;
    step();
    start16 = 1'b0; op16 = 4'd0; a16 = 16'h1111; b16 = 16'h2222;
    while (busy16 && n < 100) begin
      n++;
      step();
    end
    checks += 3;
    if (n != 1)                begin errors++; $display("FAIL m16_cycles: got %0d expected 1", n); end
    if (hi16 !== 16'h4000)     begin errors++; $display("FAIL m16_hi: got %h expected 4000", hi16); end
    if (lo16 !== 16'h0000)     begin errors++; $display("FAIL m16_lo: got %h expected 0000", lo16); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div_signed();
    test_div_corners();
    test_madd();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_mult16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
